// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo: push/clear controls in, FIFO status and serial line out.
// The master drives pushes; the slave (uart_tx_fifo) reports status and drives tx.
interface uart_tx_fifo_if #(
  parameter int CNT_W = 5
) ();
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_ovf;
  logic             full;
  logic             empty;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             tx;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, empty, busy, count, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, empty, busy, count, overflow, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serializer with a registered tx pin.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits (8E1 framing).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]    TMAX    = TW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  // Serializer state
  state_t           r_state;
  state_t           w_state_d;
  logic [TW-1:0]    r_timer;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_d;
  logic             r_tx;
  logic             w_tx_d;
  logic             w_busy;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_tick;
  logic [7:0]       w_rd_data;
  logic [CNT_W-1:0] w_count_d;

  assign w_push    = bus.wr_en && !r_full;
  assign w_drop    = bus.wr_en && r_full;
  assign w_pop     = (r_state == S_IDLE) && !r_empty;
  assign w_tick    = (r_timer == TMAX);
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // full/empty follow the next count so they stay aligned with the pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == DEPTH_C);
      r_empty <= (w_count_d == '0);
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.clr_ovf) r_overflow <= 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_d;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:   if (!r_empty) w_state_d = S_START;
      S_START:  if (w_tick) w_state_d = S_DATA;
      S_DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_d = S_PARITY;
`else
          w_state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_tick) w_state_d = S_STOP;
`endif
      S_STOP:   if (w_tick) w_state_d = S_IDLE;
      default:  w_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_shift_d = r_shift;
    if (w_pop)
      w_shift_d = w_rd_data;
    else if ((r_state == S_DATA) && w_tick)
      w_shift_d = {1'b0, r_shift[7:1]};
  end

  // FSM: outputs; tx is decoded from the next state so the pin register
  // changes on the same edge as the state it reflects
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_tx_d = 1'b1;
    case (w_state_d)
      S_START:  w_tx_d = 1'b0;
      S_DATA:   w_tx_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_d = r_parity;
`endif
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
      if (w_pop) begin
        r_timer   <= '0;
        r_bit_idx <= '0;
      end else if (r_state != S_IDLE) begin
        r_timer <= w_tick ? '0 : r_timer + TW'(1);
        if ((r_state == S_DATA) && w_tick) r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_rd_data;
  end
`endif

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.busy     = w_busy;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4: per-cycle vector table
// for fill/overflow behaviour plus hand-written frame, back-to-back and reset sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  uart_tx_fifo_if #(.CNT_W(CW)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] d;
    logic       clr;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Entry: positioned `phase` cycles into the start bit (phase 0 waits for tx low).
  // Exit: positioned on the last cycle of the stop bit.
  task automatic rx_frame(input int phase, output logic [7:0] b, output logic p);
    b = '0;
    p = 1'b0;
    if (phase == 0) begin
      for (int k = 0; k < 200 && bus.tx !== 1'b0; k++) step();
      chk("start_wait", bus.tx, 1'b0);
    end
    repeat (2 - phase) step();
    chk("start_bit", bus.tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) step();
      b[i] = bus.tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) step();
    p = bus.tx;
`endif
    repeat (CPB) step();
    chk("stop_bit", bus.tx, 1'b1);
    step();
  endtask

  task automatic frame_and_gap(input logic [7:0] exp, input int phase, input bit expect_next);
    logic [7:0] b;
    logic       p;
    rx_frame(phase, b, p);
    chk("rx_byte", b, exp);
`ifdef UART_TX_PARITY_EN
    chk("parity_bit", p, ^exp);
`endif
    step();
    chk("gap_idle", {bus.tx, bus.busy}, 2'b10);
    step();
    if (expect_next) chk("next_start", bus.tx, 1'b0);
    else             chk("stay_idle", {bus.tx, bus.busy}, 2'b10);
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    logic ok;
    n_pass  = 0;
    n_total = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;

    //          we  d      clr  tx   busy cnt   full empty ovf
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};

    repeat (3) step();
    chk("reset_state", {bus.tx, bus.empty, bus.full, bus.busy, bus.count, bus.overflow},
        {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_after_reset", {bus.tx, bus.empty, bus.busy, bus.count, bus.overflow},
          {1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    end

    // Single byte 0x55: pop and tx fall on the edge after the push
    push(8'h55);
    chk("push_55_state", {bus.tx, bus.busy, bus.count, bus.empty}, {1'b1, 1'b0, 3'd1, 1'b0});
    step();
    chk("latency_tx_fall", {bus.tx, bus.busy, bus.count, bus.empty}, {1'b0, 1'b1, 3'd0, 1'b1});
    frame_and_gap(8'h55, 0, 1'b0);

    // Back-to-back: count peaks at 2, one idle cycle between frames
    push(8'hA5);
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C; step();
    chk("b2b_count1", {bus.count, bus.tx}, {3'd1, 1'b0});
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF; step();
    bus.wr_en = 1'b0;
    chk("b2b_count_peak", bus.count, 3'd2);
    frame_and_gap(8'hA5, 1, 1'b1);
    frame_and_gap(8'h3C, 0, 1'b1);
    frame_and_gap(8'hFF, 0, 1'b0);

    // Fill to full, overflow on the sixth push, clr_ovf vs drop priority
    for (int i = 0; i < 9; i++) begin
      bus.wr_en   = tbl[i].we;
      bus.wr_data = tbl[i].d;
      bus.clr_ovf = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i),
          {bus.tx, bus.busy, bus.count, bus.full, bus.empty, bus.overflow},
          {tbl[i].tx, tbl[i].busy, tbl[i].cnt, tbl[i].full, tbl[i].empty, tbl[i].ovf});
    end
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    for (int k = 0; k < 100 && bus.busy; k++) step();
    chk("first_frame_done", bus.busy, 1'b0);
    step();
    chk("fill_next_start", bus.tx, 1'b0);
    frame_and_gap(8'h22, 0, 1'b1);
    frame_and_gap(8'h33, 0, 1'b1);
    frame_and_gap(8'h44, 0, 1'b1);
    frame_and_gap(8'h55, 0, 1'b0);
    chk("drained", {bus.count, bus.empty, bus.full, bus.overflow}, {3'd0, 1'b1, 1'b0, 1'b0});

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    step();
    frame_and_gap(8'h07, 0, 1'b0);
    push(8'h03);
    step();
    frame_and_gap(8'h03, 0, 1'b0);
`endif

    // Reset in the middle of the data bits of 0x00
    push(8'h00);
    step();
    repeat (8) step();
    chk("mid_data_low", {bus.tx, bus.busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.tx, bus.count, bus.busy, bus.empty}, {1'b1, 3'd0, 1'b0, 1'b1});
    repeat (3) step();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
    end
    chk("no_residual_frame", ok, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
